// File: rtl/prog_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader_if
// Purpose  : Byte-stream handshake plus asynchronous instruction-fetch port
//            shared between the program loader and its neighbours.
// Signals  : s_valid/s_ready/s_data/s_last  - byte stream into the loader
//            fetch_addr/fetch_data          - core fetch port out of the loader
// Modports : master - stream producer / fetching core side
//            slave  - program loader side
// Revision : 1.0 - initial release
// ============================================================================
interface prog_loader_if #(
  parameter int ADDR_W = 11
);
  logic              s_valid;
  logic              s_ready;
  logic [7:0]        s_data;
  logic              s_last;
  logic [ADDR_W-1:0] fetch_addr;
  logic [13:0]       fetch_data;

  modport master (
    output s_valid, s_data, s_last, fetch_addr,
    input  s_ready, fetch_data
  );

  modport slave (
    input  s_valid, s_data, s_last, fetch_addr,
    output s_ready, fetch_data
  );
endinterface
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Purpose  : Packs an incoming byte stream (low byte, then high byte) into
//            14-bit instruction words and writes them into a RAM program
//            memory that the core reads through a combinational fetch port.
//            cpu_hold keeps the core stalled while a load is in progress.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            bus (slave)       - byte stream in, fetch address in / data out
//            cpu_hold          - high while a load is in progress
//            load_done         - one-cycle pulse when a load terminates
//            word_count        - words written by the current/last load
//            err_format        - sticky: malformed stream
//            err_overflow      - sticky: more than DEPTH words sent
//            err_chk           - sticky: checksum mismatch
// Options  : PROG_LOADER_CHECKSUM_EN - when defined, the stream ends with a
//            mod-256 checksum byte carrying s_last; otherwise err_chk is 0.
// Revision : 1.0 - initial release
// ============================================================================
module prog_loader #(
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  prog_loader_if.slave      bus,
  output logic              cpu_hold,
  output logic              load_done,
  output logic [ADDR_W:0]   word_count,
  output logic              err_format,
  output logic              err_overflow,
  output logic              err_chk
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] PTR_MAX = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LO   = 3'd1,
    S_HI   = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      lo_q, lo_d;
  logic [5:0]      hi_q, hi_d;
  logic            last_q, last_d;
  // Write pointer doubles as the word counter: both advance once per WR
  // and saturate at 2**ADDR_W.
  logic [ADDR_W:0] ptr_q, ptr_d;
  logic            err_fmt_q, err_fmt_d;
  logic            err_ovf_q, err_ovf_d;
  logic            wr_en;
  logic            w_accept;
  logic [13:0]     mem [DEPTH];

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       err_chk_q, err_chk_d;
  logic [7:0] w_sum_base;
  // The running sum restarts with the first byte of a load.
  assign w_sum_base = (state_q == S_IDLE) ? 8'h00 : sum_q;
  assign err_chk    = err_chk_q;
`else
  assign err_chk    = 1'b0;
`endif

  assign w_accept     = bus.s_valid && bus.s_ready;
  assign word_count   = ptr_q;
  assign err_format   = err_fmt_q;
  assign err_overflow = err_ovf_q;

  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    last_d      = last_q;
    ptr_d       = ptr_q;
    err_fmt_d   = err_fmt_q;
    err_ovf_d   = err_ovf_q;
    wr_en       = 1'b0;
    bus.s_ready = 1'b0;
    cpu_hold    = 1'b0;
    load_done   = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
    err_chk_d   = err_chk_q;
`endif
    case (state_q)
      S_IDLE, S_LO: begin
        bus.s_ready = 1'b1;
        cpu_hold    = (state_q == S_LO);
        if (w_accept) begin
          if (state_q == S_IDLE) begin
            ptr_d     = '0;
            err_fmt_d = 1'b0;
            err_ovf_d = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            err_chk_d = 1'b0;
`endif
          end
          if (bus.s_last) begin
            // Byte in low position closes the load; any partial word is lost.
`ifdef PROG_LOADER_CHECKSUM_EN
            err_chk_d = (bus.s_data != w_sum_base);
`else
            err_fmt_d = 1'b1;
`endif
            state_d = S_DONE;
          end else begin
            lo_d    = bus.s_data;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_d   = w_sum_base + bus.s_data;
`endif
            state_d = S_HI;
          end
        end
      end
      S_HI: begin
        bus.s_ready = 1'b1;
        cpu_hold    = 1'b1;
        if (w_accept) begin
          hi_d   = bus.s_data[5:0];
          last_d = bus.s_last;
          if (bus.s_data[7:6] != 2'b00) err_fmt_d = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d  = sum_q + bus.s_data;
          // Ending on a high byte means the checksum byte never arrived.
          if (bus.s_last) err_fmt_d = 1'b1;
`endif
          state_d = S_WR;
        end
      end
      S_WR: begin
        cpu_hold = 1'b1;
        if (ptr_q < DEPTH_C) wr_en = 1'b1;
        else                 err_ovf_d = 1'b1;
        if (ptr_q != PTR_MAX) ptr_d = ptr_q + 1'b1;
        state_d = last_q ? S_DONE : S_LO;
      end
      S_DONE: begin
        load_done = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      lo_q      <= '0;
      hi_q      <= '0;
      last_q    <= 1'b0;
      ptr_q     <= '0;
      err_fmt_q <= 1'b0;
      err_ovf_q <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q     <= '0;
      err_chk_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      last_q    <= last_d;
      ptr_q     <= ptr_d;
      err_fmt_q <= err_fmt_d;
      err_ovf_q <= err_ovf_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q     <= sum_d;
      err_chk_q <= err_chk_d;
`endif
    end
  end

  // Program memory is deliberately not reset so a reset keeps loaded code.
  always_ff @(posedge clk) begin
    if (wr_en) mem[ptr_q[IDX_W-1:0]] <= {hi_q, lo_q};
  end

  // Combinational fetch; a read of the word being written sees the old value.
  assign bus.fetch_data = ({1'b0, bus.fetch_addr} < DEPTH_C)
                          ? mem[bus.fetch_addr[IDX_W-1:0]] : 14'h0;

endmodule
`default_nettype wire

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the instruction-fetch interface: receives a byte stream, packs it into 14-bit instruction words and writes them into a RAM program memory.
- The processor core reads the same memory through an asynchronous fetch port, using the same addressing and data it uses for its ROM today.
- cpu_hold keeps the core stalled/reset while a load is in progress.

Parameters:
- ADDR_W, 11, fetch/write address width (matches the core's PC/MAR width).
- DEPTH, 64, number of implemented 14-bit words; must satisfy DEPTH <= 2**ADDR_W.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  synchronous, active-high.
- s_valid  in  1  byte-stream valid.
- s_ready  out  1  byte-stream ready; a byte is accepted when s_valid && s_ready on a rising clk edge.
- s_data  in  8  stream byte.
- s_last  in  1  marks the final byte of a load.
- fetch_addr  in  ADDR_W  core fetch address.
- fetch_data  out  14  instruction word at fetch_addr.
- cpu_hold  out  1  high while a load is in progress.
- load_done  out  1  one-cycle pulse when a load terminates.
- word_count  out  ADDR_W+1  words written by the current/last load.
- err_format  out  1  sticky: malformed stream.
- err_overflow  out  1  sticky: more than DEPTH words sent.
- err_chk  out  1  sticky checksum error; constant 0 without PROG_LOADER_CHECKSUM_EN.

Behaviour:
- Reset values:
  - state=IDLE, s_ready=1, cpu_hold=0, load_done=0, word_count=0, all err_* = 0, write pointer = 0.
  - Memory contents are not reset.
- Word format: low byte first = word[7:0]; high byte second = word[13:8] from s_data[5:0].
  - A high byte with s_data[7:6] != 0 sets err_format. The word is still written.
- States:
  - IDLE: s_ready=1, cpu_hold=0. On accept: capture low byte, clear word_count, write pointer and all err_*, go HI.
  - LO: s_ready=1, cpu_hold=1. On accept: capture low byte, go HI.
  - HI: s_ready=1, cpu_hold=1. On accept: capture high byte, record s_last, go WR.
  - WR: s_ready=0, cpu_hold=1.
    - Write mem[ptr] if ptr < DEPTH; otherwise discard and set err_overflow.
    - Increment ptr and word_count, saturating at 2**ADDR_W.
    - Go DONE if recorded last, else LO.
  - DONE: s_ready=0, cpu_hold=0, load_done=1 for exactly this cycle. Go IDLE.
- s_last on a low byte (accepted in IDLE or LO): partial word discarded, err_format set, go DONE.
- Throughput: 3 cycles per word with a continuously valid stream. The written word is visible on fetch_data the cycle after WR.
- Fetch port:
  - Combinational: fetch_data = mem[fetch_addr] when fetch_addr < DEPTH, else 14'h0.
  - Readable in every state.
  - A read of the address being written in WR returns the old value that cycle.
- Reset mid-load: state returns to IDLE immediately and cpu_hold drops. Words already written stay in memory; the partial word is lost.
- A byte whose s_valid and s_last are both high in IDLE is a one-byte load, handled per the s_last-on-low-byte rule.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- With the macro defined:
  - The stream ends with one checksum byte following a complete word; that byte carries s_last.
  - The checksum is the 8-bit modulo-256 sum of all preceding bytes of the load.
  - s_last on a byte in low position is treated as the checksum: compare against the running sum, set err_chk on mismatch, go DONE. This is not a format error.
  - s_last on a high byte writes the word, sets err_format (checksum missing), and terminates.
  - The running sum clears on IDLE accept.
- Without the macro: err_chk is tied 0, and the framing rules above apply unchanged.

Test Plan:
- Load bytes 44 30 01 3E 02 38 FE 39 47 3C 55 3A AA 3A, s_last on the final byte, then sweep fetch_addr 0..6 -> fetch_data 3044, 3E01, 3802, 39FE, 3C47, 3A55, 3AAA. word_count=7, one load_done pulse, no errors, cpu_hold high from the cycle after the first accept until DONE.
- Same stream with s_valid toggled randomly -> identical memory contents. s_ready is low only in WR/DONE.
- Assert reset after 3 words have been written, then reload words 0x0001, 0x0002 -> addr 0..1 hold the new words, addr 2 still holds 3802, word_count=2.
- DEPTH=64, send 65 words -> err_overflow=1, word_count=65, addr 0..63 correct, word 65 absent.
- Send 44 30 01 with s_last on the 01 byte -> err_format=1, word_count=1, mem[1] unchanged. Separately, high byte 0xC0 -> err_format=1 and the word is written as 0x00xx.
- With PROG_LOADER_CHECKSUM_EN: send 44 30 then checksum 74 with s_last -> err_chk=0. Send 44 30 then 75 -> err_chk=1. In both cases mem[0]=3044.
